fixed_mult_arbiter: RTL and testbench

Shares one sign-magnitude fixed-point multiplier between `NUM_REQ` requesters. The block arbitrates round-robin, captures the granted operands, and sequences a two-stage registered multiply. It returns the result with an overflow flag and the requester ID over a valid/ready response port. It sits between the fixed-point datapath clients and the single multiplier resource, so one multiply is in flight at a time.

---
 rtl/fixed_mult_pkg.sv | 19 +
 rtl/fixed_mult_pipe.sv | 63 ++++++
 rtl/fixed_mult_arbiter.sv | 113 +++++++++++
 tb/tb_fixed_mult_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fixed_mult_pkg.sv
// Shared types and defaults for the round-robin fixed-point multiplier arbiter.
package fixed_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_N = 32;
  localparam int DEF_Q = 15;

  // A single requester still needs a one-bit ID field.
  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fixed_mult_pipe.sv
// Two registered stages of the sign-magnitude fixed-point multiply.
// FIXED_MULT_SAT_EN selects saturation of the magnitude on overflow instead of wrap.
module fixed_mult_pipe
  import fixed_mult_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int Q = DEF_Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stage1_en,
  input  logic         stage2_en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] data,
  output logic         ovr
);

  localparam int MW = 2*N-2;

  logic          sign_reg;
  logic [MW-1:0] mag_reg;
  logic [N-2:0]  slice_mag;
  logic [N-2:0]  mag_next;
  logic          ovr_next;
  logic [N-1:0]  data_reg;
  logic          ovr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg <= 1'b0;
      mag_reg  <= '0;
    end else if (stage1_en) begin
      sign_reg <= a[N-1] ^ b[N-1];
      mag_reg  <= MW'(a[N-2:0]) * MW'(b[N-2:0]);
    end
  end

  // Truncate to the Q-aligned window; anything above it is overflow.
  always_comb begin
    slice_mag = mag_reg[N-2+Q:Q];
    ovr_next  = |mag_reg[MW-1:N-1+Q];
`ifdef FIXED_MULT_SAT_EN
    mag_next  = ovr_next ? '1 : slice_mag;
`else
    mag_next  = slice_mag;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      ovr_reg  <= 1'b0;
    end else if (stage2_en) begin
      data_reg <= {sign_reg & (|mag_next), mag_next};
      ovr_reg  <= ovr_next;
    end
  end

  assign data = data_reg;
  assign ovr  = ovr_reg;

endmodule

// File: rtl/fixed_mult_arbiter.sv
// Round-robin arbiter sharing one two-stage fixed-point multiplier among NUM_REQ clients.
// Build with FIXED_MULT_SAT_EN to saturate overflowing magnitudes.
module fixed_mult_arbiter
  import fixed_mult_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int Q       = DEF_Q,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic [NUM_REQ-1:0]   in_req_valid,
  output logic [NUM_REQ-1:0]   out_req_ready,
  input  logic [NUM_REQ*N-1:0] in_req_a,
  input  logic [NUM_REQ*N-1:0] in_req_b,
  output logic                 out_rsp_valid,
  input  logic                 in_rsp_ready,
  output logic [N-1:0]         out_rsp_data,
  output logic                 out_rsp_ovr,
  output logic [ID_W-1:0]      out_rsp_id
);

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0] id_reg, rsp_id_reg;
  logic [ID_W-1:0] grant_idx, cand;
  logic            grant_found;
  logic            accept, stage1_en, stage2_en;
  logic [N-1:0]    a_reg, b_reg;
  logic [N-1:0]    req_a [NUM_REQ];
  logic [N-1:0]    req_b [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_a[gi]         = in_req_a[gi*N +: N];
      assign req_b[gi]         = in_req_b[gi*N +: N];
      assign out_req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!grant_found && in_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_ptr_next = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = MUL1;
      MUL1:    state_next = MUL2;
      MUL2:    state_next = RESP;
      RESP:    if (in_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant strobe is held off while reset is asserted even though the FSM sits in IDLE.
  always_comb begin
    accept        = in_rst_n && (state_reg == IDLE) && grant_found;
    stage1_en     = (state_reg == MUL1);
    stage2_en     = (state_reg == MUL2);
    out_rsp_valid = (state_reg == RESP);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      rsp_id_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      if (accept) begin
        rr_ptr_reg <= rr_ptr_next;
        id_reg     <= grant_idx;
        a_reg      <= req_a[grant_idx];
        b_reg      <= req_b[grant_idx];
      end
      if (stage2_en) rsp_id_reg <= id_reg;
    end
  end

  fixed_mult_pipe #(.N(N), .Q(Q)) u_pipe (
    .clk       (in_clk),
    .rst_n     (in_rst_n),
    .stage1_en (stage1_en),
    .stage2_en (stage2_en),
    .a         (a_reg),
    .b         (b_reg),
    .data      (out_rsp_data),
    .ovr       (out_rsp_ovr)
  );

  assign out_rsp_id = rsp_id_reg;

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Directed bench for fixed_mult_arbiter (N=32, Q=15, four requesters).
module tb_fixed_mult_arbiter;

  localparam int N       = 32;
  localparam int Q       = 15;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [N-1:0]         rsp_data;
  logic                 rsp_ovr;
  logic [ID_W-1:0]      rsp_id;

  int n_cmp = 0;
  int n_err = 0;

  fixed_mult_arbiter #(.N(N), .Q(Q), .NUM_REQ(NUM_REQ)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_req_valid  (req_valid),
    .out_req_ready (req_ready),
    .in_req_a      (req_a),
    .in_req_b      (req_b),
    .out_rsp_valid (rsp_valid),
    .in_rsp_ready  (rsp_ready),
    .out_rsp_data  (rsp_data),
    .out_rsp_ovr   (rsp_ovr),
    .out_rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the FSM in IDLE; returns at a falling edge in IDLE.
  task automatic run_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input logic exp_ovr, input string tag);
    logic [NUM_REQ-1:0] onehot;
    onehot = NUM_REQ'(1 << idx);
    req_valid[idx]       = 1'b1;
    req_a[idx*N +: N]    = a;
    req_b[idx*N +: N]    = b;
    #1 chk({tag, ".grant"}, 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid[idx] = 1'b0;
    chk({tag, ".busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".early"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".data"}, rsp_data, exp_data);
    chk({tag, ".ovr"}, 32'(rsp_ovr), 32'(exp_ovr));
    chk({tag, ".id"}, 32'(rsp_id), 32'(idx));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ovr_data;
`ifdef FIXED_MULT_SAT_EN
    ovr_data = 32'h7FFF_FFFF;
`else
    ovr_data = 32'h0000_0000;
`endif
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state, with all requests raised to show the grant is held off.
    #3;
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.data", rsp_data, 32'd0);
    chk("rst.ovr", 32'(rsp_ovr), 32'd0);
    chk("rst.id", 32'(rsp_id), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, "t1.5x2");
    run_txn(2, 32'h8000_C000, 32'h0001_0000, 32'h8001_8000, 1'b0, "tneg");
    run_txn(1, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, "tnegzero");
    run_txn(3, 32'h4000_0000, 32'h4000_0000, ovr_data,       1'b1, "tovr");
    run_txn(0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, "ttiny");
    run_txn(1, 32'h8001_0000, 32'h8001_0000, 32'h0002_0000, 1'b0, "tnegneg");

    // Backpressure: requester 3 waits while the response of requester 2 is held.
    req_valid[2]      = 1'b1;
    req_a[2*N +: N]   = 32'h0000_8000;
    req_b[2*N +: N]   = 32'h0000_8000;
    #1 chk("bp.grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid[2]    = 1'b0;
    req_valid[3]    = 1'b1;
    req_a[3*N +: N] = 32'hFFFF_FFFF;
    req_b[3*N +: N] = 32'h0000_8000;
    chk("bp.mul1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp.mul2", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("bp.valid", 32'(rsp_valid), 32'd1);
      chk("bp.data", rsp_data, 32'h0000_8000);
      chk("bp.ovr", 32'(rsp_ovr), 32'd0);
      chk("bp.id", 32'(rsp_id), 32'd2);
      chk("bp.ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp.still", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.consumed", 32'(rsp_valid), 32'd0);
    run_txn(3, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0, "tmaxneg");

    // Reset pulse while requester 1's multiply is in MUL2.
    req_valid[1]    = 1'b1;
    req_a[1*N +: N] = 32'h0000_C000;
    req_b[1*N +: N] = 32'h0001_0000;
    #1 chk("rs.grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rs.valid", 32'(rsp_valid), 32'd0);
    chk("rs.data", rsp_data, 32'd0);
    chk("rs.ovr", 32'(rsp_ovr), 32'd0);
    chk("rs.id", 32'(rsp_id), 32'd0);
    chk("rs.ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rs.norsp", 32'(rsp_valid), 32'd0);
    end

    // All requesters held valid: grants rotate 0,1,2,3,0,1.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*N +: N] = 32'((i + 1) << Q);
      req_b[i*N +: N] = 32'h0001_0000;
    end
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr.grant", 32'(req_ready), 32'(1 << (k % NUM_REQ)));
      @(negedge clk);
      chk("rr.busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rr.valid", 32'(rsp_valid), 32'd1);
      chk("rr.id", 32'(rsp_id), 32'(k % NUM_REQ));
      chk("rr.data", rsp_data, 32'(((k % NUM_REQ) + 1) << 16));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
